// File: rtl/lcd_cmd_engine.sv
// HD44780-class character-LCD write engine with a start/done custom-instruction handshake.
// Define LCD_INIT_SEQ_EN to add the power-on wait and ROM-driven initialisation sequence.
module lcd_cmd_engine #(
    parameter int BUS_W     = 8,
    parameter int T_SETUP   = 5,
    parameter int T_PULSE   = 25,
    parameter int T_EXEC    = 2500,
    parameter int T_LONG    = 100000,
    parameter int T_POWERON = 750000,
    parameter int CNT_W     = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_en,
    input  logic             start,
    input  logic [31:0]      data_a,
    input  logic [31:0]      data_b,
    output logic [31:0]      result,
    output logic             done,
    output logic             ready,
    output logic             LCD_rs,
    output logic             LCD_rw,
    output logic             LCD_en,
    output logic [BUS_W-1:0] LCD_dados
);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_GAP, S_WAIT, S_DONE
    } state_t;

    localparam bit NIBBLE = (BUS_W == 4);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    // WAIT terminates at T_W rather than T_W-1: the extra cycle is the turnaround into DONE.
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [7:0]         byte_q, byte_n;
    logic               long_q, long_n;
    logic               nib_q, nib_n;
    logic               single_q, single_n;
    logic               rs_n, en_n, done_n, ready_n;
    logic [BUS_W-1:0]   dados_n;
    logic [31:0]        result_n;

`ifdef LCD_INIT_SEQ_EN
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_POWERON - 1);
    localparam logic [3:0]       INIT_LEN = NIBBLE ? 4'd8 : 4'd7;
    localparam state_t           RST_STATE = S_PWR;

    logic [3:0] idx_q, idx_n;
    logic       boot_q, boot_n;
    logic [9:0] rom_entry;

    // Entry format {long_wait, single_nibble, byte}; single nibbles only matter on a 4-bit bus.
    function automatic logic [9:0] init_rom(input logic [3:0] i);
        logic [9:0] e;
        e = '0;
        if (NIBBLE) begin
            case (i)
                4'd0:    e = {1'b1, 1'b1, 8'h30};
                4'd1:    e = {1'b0, 1'b1, 8'h30};
                4'd2:    e = {1'b0, 1'b1, 8'h30};
                4'd3:    e = {1'b0, 1'b1, 8'h20};
                4'd4:    e = {1'b0, 1'b0, 8'h28};
                4'd5:    e = {1'b0, 1'b0, 8'h0C};
                4'd6:    e = {1'b1, 1'b0, 8'h01};
                4'd7:    e = {1'b0, 1'b0, 8'h06};
                default: e = '0;
            endcase
        end else begin
            case (i)
                4'd0:    e = {1'b1, 1'b0, 8'h30};
                4'd1:    e = {1'b0, 1'b0, 8'h30};
                4'd2:    e = {1'b0, 1'b0, 8'h30};
                4'd3:    e = {1'b0, 1'b0, 8'h38};
                4'd4:    e = {1'b0, 1'b0, 8'h0C};
                4'd5:    e = {1'b1, 1'b0, 8'h01};
                4'd6:    e = {1'b0, 1'b0, 8'h06};
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    assign rom_entry = init_rom(idx_q);
`else
    localparam state_t RST_STATE = S_IDLE;
    logic unused_cfg;
    assign unused_cfg = ^{CNT_W'(T_POWERON)};
`endif

    logic unused_bits;
    assign unused_bits = ^{data_a[31:2], data_b[31:8]};

    assign LCD_rw = 1'b0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_n  = state_q;
        cnt_n    = '0;
        byte_n   = byte_q;
        long_n   = long_q;
        nib_n    = nib_q;
        single_n = single_q;
        rs_n     = LCD_rs;
        en_n     = LCD_en;
        dados_n  = LCD_dados;
        done_n   = 1'b0;
        result_n = result;
`ifdef LCD_INIT_SEQ_EN
        idx_n    = idx_q;
        boot_n   = boot_q;
`endif
        case (state_q)
`ifdef LCD_INIT_SEQ_EN
            S_PWR: begin
                if (cnt_q == PWR_LAST) state_n = S_INIT;
                else                   cnt_n   = cnt_q + CNT_W'(1);
            end
            S_INIT: begin
                if (idx_q == INIT_LEN) begin
                    state_n = S_IDLE;
                    boot_n  = 1'b0;
                end else begin
                    byte_n   = rom_entry[7:0];
                    long_n   = rom_entry[9];
                    single_n = rom_entry[8];
                    nib_n    = 1'b0;
                    boot_n   = 1'b1;
                    rs_n     = 1'b0;
                    dados_n  = rom_entry[7 -: BUS_W];
                    state_n  = S_SETUP;
                end
            end
`endif
            S_IDLE: begin
                if (start) begin
                    byte_n   = data_b[7:0];
                    rs_n     = data_a[0];
                    long_n   = data_a[1] ||
                               (!data_a[0] && (data_b[7:0] inside {8'h01, 8'h02, 8'h03}));
                    nib_n    = 1'b0;
                    single_n = 1'b0;
                    dados_n  = data_b[7 -: BUS_W];
                    state_n  = S_SETUP;
                end
            end
            S_SETUP, S_GAP: begin
                if (cnt_q == SETUP_LAST) begin
                    en_n    = 1'b1;
                    state_n = S_PULSE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    en_n = 1'b0;
                    if (NIBBLE && !nib_q && !single_q) begin
                        nib_n   = 1'b1;
                        dados_n = byte_q[BUS_W-1:0];
                        state_n = S_GAP;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == (long_q ? LONG_LAST : EXEC_LAST)) begin
`ifdef LCD_INIT_SEQ_EN
                    if (boot_q) begin
                        idx_n   = idx_q + 4'd1;
                        state_n = S_INIT;
                    end else begin
                        done_n   = 1'b1;
                        result_n = {23'b0, LCD_rs, byte_q};
                        state_n  = S_DONE;
                    end
`else
                    done_n   = 1'b1;
                    result_n = {23'b0, LCD_rs, byte_q};
                    state_n  = S_DONE;
`endif
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            byte_q    <= '0;
            long_q    <= 1'b0;
            nib_q     <= 1'b0;
            single_q  <= 1'b0;
            LCD_rs    <= 1'b0;
            LCD_en    <= 1'b0;
            LCD_dados <= '0;
            done      <= 1'b0;
            result    <= '0;
            ready     <= (RST_STATE == S_IDLE);
`ifdef LCD_INIT_SEQ_EN
            idx_q     <= '0;
            boot_q    <= 1'b0;
`endif
        end else if (clock_en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            byte_q    <= byte_n;
            long_q    <= long_n;
            nib_q     <= nib_n;
            single_q  <= single_n;
            LCD_rs    <= rs_n;
            LCD_en    <= en_n;
            LCD_dados <= dados_n;
            done      <= done_n;
            result    <= result_n;
            ready     <= ready_n;
`ifdef LCD_INIT_SEQ_EN
            idx_q     <= idx_n;
            boot_q    <= boot_n;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Scoreboard bench for lcd_cmd_engine: an 8-bit and a 4-bit instance with short timing parameters.
// Expected LCD_en pulses and done events are queued by the stimulus and popped by a negedge monitor.
module tb_lcd_cmd_engine;

    localparam int T_SETUP   = 2;
    localparam int T_PULSE   = 3;
    localparam int T_EXEC    = 10;
    localparam int T_LONG    = 40;
    localparam int T_POWERON = 50;
    localparam int CNT_W     = 8;
`ifdef LCD_INIT_SEQ_EN
    localparam logic READY_RST = 1'b0;
`else
    localparam logic READY_RST = 1'b1;
`endif

    typedef struct {
        int         d;
        logic [8:0] val;   // {rs, data pins zero-extended to 8 bits}
        int         len;
        longint     due;   // edge where LCD_en rises, -1 when not checked
    } xfer_t;

    typedef struct {
        int          d;
        logic [31:0] res;
        longint      due;  // edge where done rises
    } done_t;

    logic        clock = 1'b0;
    logic        rst8, rst4, ce8, ce4, start8, start4;
    logic [31:0] data_a, data_b;
    logic [31:0] r8, r4;
    logic        done8, done4, ready8, ready4, rs8, rs4, rw8, rw4, en8, en4;
    logic [7:0]  dd8;
    logic [3:0]  dd4;

    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;
    xfer_t  xq[$];
    done_t  dq[$];

    logic       en_prev [2] = '{1'b0, 1'b0};
    logic       done_prev [2] = '{1'b0, 1'b0};
    bit         drop [2] = '{1'b0, 1'b0};
    int         hi [2] = '{0, 0};
    longint     rise [2] = '{0, 0};
    logic [8:0] cap [2] = '{9'h0, 9'h0};

    lcd_cmd_engine #(
        .BUS_W(8), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_EXEC(T_EXEC),
        .T_LONG(T_LONG), .T_POWERON(T_POWERON), .CNT_W(CNT_W)
    ) dut8 (
        .clock(clock), .reset(rst8), .clock_en(ce8), .start(start8),
        .data_a(data_a), .data_b(data_b), .result(r8), .done(done8), .ready(ready8),
        .LCD_rs(rs8), .LCD_rw(rw8), .LCD_en(en8), .LCD_dados(dd8)
    );

    lcd_cmd_engine #(
        .BUS_W(4), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_EXEC(T_EXEC),
        .T_LONG(T_LONG), .T_POWERON(T_POWERON), .CNT_W(CNT_W)
    ) dut4 (
        .clock(clock), .reset(rst4), .clock_en(ce4), .start(start4),
        .data_a(data_a), .data_b(data_b), .result(r4), .done(done4), .ready(ready4),
        .LCD_rs(rs4), .LCD_rw(rw4), .LCD_en(en4), .LCD_dados(dd4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_x(input int d, input logic [8:0] val, input int len, input longint due);
        xfer_t x;
        x.d = d; x.val = val; x.len = len; x.due = due;
        xq.push_back(x);
    endtask

    task automatic push_d(input int d, input logic [31:0] res, input longint due);
        done_t e;
        e.d = d; e.res = res; e.due = due;
        dq.push_back(e);
    endtask

    // Raises start at a negedge; s is the edge on which the DUT samples it.
    task automatic fire(input int d, input logic [31:0] a, input logic [31:0] b, output longint s);
        @(negedge clock);
        data_a = a;
        data_b = b;
        if (d == 0) start8 = 1'b1;
        else        start4 = 1'b1;
        s = cyc + 1;
    endtask

    task automatic drop_start();
        @(negedge clock);
        start8 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            #1;
            if (((d == 0) ? ready8 : ready4) && xq.size() == 0 && dq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("idle_timeout_dut%0d", d));
    endtask

    task automatic wait_en(input int d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if ((d == 0) ? en8 : en4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("en_timeout_dut%0d", d));
    endtask

    // Monitor: one LCD_en pulse or done rise pops one scoreboard entry.
    always @(negedge clock) begin : monitor
        logic        en_now, done_now;
        logic [8:0]  rsdd;
        logic [31:0] res;
        xfer_t       x;
        done_t       e;
        for (int d = 0; d < 2; d++) begin
            en_now   = (d == 0) ? en8 : en4;
            done_now = (d == 0) ? done8 : done4;
            rsdd     = (d == 0) ? {rs8, dd8} : {rs4, 4'h0, dd4};
            res      = (d == 0) ? r8 : r4;
            if (drop[d]) begin
                drop[d]      = 1'b0;
                en_prev[d]   = 1'b0;
                done_prev[d] = 1'b0;
                hi[d]        = 0;
            end else begin
                if (en_now && !en_prev[d]) begin
                    cap[d]  = rsdd;
                    rise[d] = cyc;
                    hi[d]   = 1;
                end else if (en_now) begin
                    hi[d]++;
                end else if (en_prev[d]) begin
                    if (xq.size() == 0) begin
                        fail_now($sformatf("xfer_unexpected_dut%0d", d));
                    end else begin
                        x = xq.pop_front();
                        check("xfer_dut", 64'(d), 64'(x.d));
                        check("xfer_rs_data", 64'(cap[d]), 64'(x.val));
                        check("xfer_pulse_len", 64'(hi[d]), 64'(x.len));
                        if (x.due >= 0) check("xfer_rise_cycle", 64'(rise[d]), 64'(x.due));
                    end
                end
                if (done_now && !done_prev[d]) begin
                    if (dq.size() == 0) begin
                        fail_now($sformatf("done_unexpected_dut%0d", d));
                    end else begin
                        e = dq.pop_front();
                        check("done_dut", 64'(d), 64'(e.d));
                        check("done_result", 64'(res), 64'(e.res));
                        check("done_cycle", 64'(cyc), 64'(e.due));
                    end
                end
                en_prev[d]   = en_now;
                done_prev[d] = done_now;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint s;
        rst8 = 1'b1; rst4 = 1'b1; ce8 = 1'b1; ce4 = 1'b1;
        start8 = 1'b0; start4 = 1'b0; data_a = '0; data_b = '0;
        #1;
        check("rst_en", en8, 1'b0);
        check("rst_rs", rs8, 1'b0);
        check("rst_dados", dd8, 8'h00);
        check("rst_done", done8, 1'b0);
        check("rst_result", r8, 32'h0);
        check("rst_ready", ready8, READY_RST);
        check("rst_rw", rw8, 1'b0);
        check("rst_en4", en4, 1'b0);
        repeat (3) @(negedge clock);

`ifdef LCD_INIT_SEQ_EN
        push_x(0, {1'b0, 8'h30}, 3, -1);
        push_x(0, {1'b0, 8'h30}, 3, -1);
        push_x(0, {1'b0, 8'h30}, 3, -1);
        push_x(0, {1'b0, 8'h38}, 3, -1);
        push_x(0, {1'b0, 8'h0C}, 3, -1);
        push_x(0, {1'b0, 8'h01}, 3, -1);
        push_x(0, {1'b0, 8'h06}, 3, -1);
        rst8 = 1'b0;
        repeat (40) @(negedge clock);
        check("init8_ready_low_in_pwr", ready8, 1'b0);
        wait_idle(0, 1500);
        check("init8_result_untouched", r8, 32'h0);
        foreach (dq[i]) check("init_dq_empty", 64'(i), 64'hFFFF);
        push_x(1, {1'b0, 8'h03}, 3, -1);
        push_x(1, {1'b0, 8'h03}, 3, -1);
        push_x(1, {1'b0, 8'h03}, 3, -1);
        push_x(1, {1'b0, 8'h02}, 3, -1);
        push_x(1, {1'b0, 8'h02}, 3, -1);
        push_x(1, {1'b0, 8'h08}, 3, -1);
        push_x(1, {1'b0, 8'h00}, 3, -1);
        push_x(1, {1'b0, 8'h0C}, 3, -1);
        push_x(1, {1'b0, 8'h00}, 3, -1);
        push_x(1, {1'b0, 8'h01}, 3, -1);
        push_x(1, {1'b0, 8'h00}, 3, -1);
        push_x(1, {1'b0, 8'h06}, 3, -1);
        rst4 = 1'b0;
        wait_idle(1, 1500);
        check("init4_ready", ready4, 1'b1);
`else
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clock);
        check("ready8_after_reset", ready8, 1'b1);
        check("ready4_after_reset", ready4, 1'b1);
`endif

        // 8-bit data write, normal wait
        fire(0, 32'h1, 32'h41, s);
        push_x(0, {1'b1, 8'h41}, 3, s + 2);
        push_d(0, 32'h141, s + 16);
        drop_start();
        wait_idle(0, 200);
        check("hold_rs", rs8, 1'b1);
        check("hold_dados", dd8, 8'h41);
        check("idle_rw", rw8, 1'b0);

        // clear display: automatic long wait
        fire(0, 32'h0, 32'h01, s);
        push_x(0, {1'b0, 8'h01}, 3, s + 2);
        push_d(0, 32'h001, s + 46);
        drop_start();
        wait_idle(0, 200);

        // forced long wait, upper data bits ignored
        fire(0, 32'hFFFF_FFF2, 32'hABCD_EF80, s);
        push_x(0, {1'b0, 8'h80}, 3, s + 2);
        push_d(0, 32'h080, s + 46);
        drop_start();
        wait_idle(0, 200);

        // 0x01 as data (rs=1) is not a clear: normal wait
        fire(0, 32'h1, 32'h01, s);
        push_x(0, {1'b1, 8'h01}, 3, s + 2);
        push_d(0, 32'h101, s + 16);
        drop_start();
        wait_idle(0, 200);

        // home (0x03 instruction) takes the long wait, 0x04 does not
        fire(0, 32'h0, 32'h03, s);
        push_x(0, {1'b0, 8'h03}, 3, s + 2);
        push_d(0, 32'h003, s + 46);
        drop_start();
        wait_idle(0, 200);
        fire(0, 32'h0, 32'h04, s);
        push_x(0, {1'b0, 8'h04}, 3, s + 2);
        push_d(0, 32'h004, s + 16);
        drop_start();
        wait_idle(0, 200);

        // 4-bit data write: upper nibble then lower nibble
        fire(1, 32'h1, 32'hA5, s);
        push_x(1, {1'b1, 8'h0A}, 3, s + 2);
        push_x(1, {1'b1, 8'h05}, 3, s + 7);
        push_d(1, 32'h1A5, s + 21);
        drop_start();
        wait_idle(1, 200);
        check("hold_dados4", dd4, 4'h5);

        // 4-bit return-home instruction with long wait
        fire(1, 32'h0, 32'h02, s);
        push_x(1, {1'b0, 8'h00}, 3, s + 2);
        push_x(1, {1'b0, 8'h02}, 3, s + 7);
        push_d(1, 32'h002, s + 51);
        drop_start();
        wait_idle(1, 200);

        // clock_en low for 7 cycles mid-pulse; starts while busy are ignored
        fire(0, 32'h1, 32'h5A, s);
        push_x(0, {1'b1, 8'h5A}, 10, s + 2);
        push_d(0, 32'h15A, s + 23);
        drop_start();
        wait_en(0, 20);
        ce8 = 1'b0;
        data_b = 32'hFF;
        start8 = 1'b1;
        repeat (7) @(negedge clock);
        ce8 = 1'b1;
        start8 = 1'b0;
        @(negedge clock);
        start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        wait_idle(0, 200);

        // start in IDLE with clock_en low is ignored
        @(negedge clock);
        ce8 = 1'b0;
        data_a = 32'h1;
        data_b = 32'h77;
        start8 = 1'b1;
        repeat (3) @(negedge clock);
        start8 = 1'b0;
        ce8 = 1'b1;
        repeat (60) @(negedge clock);
        check("ignored_start_result", r8, 32'h15A);
        check("ignored_start_ready", ready8, 1'b1);

        // reset mid-pulse: EN drops asynchronously, no done follows
        fire(0, 32'h1, 32'h33, s);
        drop_start();
        wait_en(0, 20);
        #1;
        rst8 = 1'b1;
        #1;
        drop[0] = 1'b1;
        check("abort_en", en8, 1'b0);
        check("abort_rs", rs8, 1'b0);
        check("abort_dados", dd8, 8'h00);
        check("abort_done", done8, 1'b0);
        check("abort_result", r8, 32'h0);
        check("abort_ready", ready8, READY_RST);
        repeat (2) @(negedge clock);
        rst8 = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_no_done", done8, 1'b0);
        check("xq_drained", 64'(xq.size()), 64'd0);
        check("dq_drained", 64'(dq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
